// File: rtl/hangman_pkg.sv
// hangman_pkg: shared types and constants for the hangman game logic.
//   state_t      - guess_tracker FSM states
//   MAX_LEN_DEF  - default maximum word length (characters)
//   MAX_MISSES_DEF - default wrong guesses allowed before loss
//   CH_*         - ASCII letter bounds
//   to_lower()   - folds 'A'..'Z' to 'a'..'z', other codes pass through
package hangman_pkg;

    localparam int MAX_LEN_DEF    = 11;
    localparam int MAX_MISSES_DEF = 6;

    localparam logic [7:0] CH_A_LOWER = 8'h61; // 'a'
    localparam logic [7:0] CH_Z_LOWER = 8'h7A; // 'z'
    localparam logic [7:0] CH_A_UPPER = 8'h41; // 'A'
    localparam logic [7:0] CH_Z_UPPER = 8'h5A; // 'Z'

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } state_t;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= CH_A_UPPER && c <= CH_Z_UPPER) begin
            return c + 8'd32;
        end
        return c;
    endfunction

endpackage

// File: rtl/letter_match.sv
// letter_match: combinational compare of one character against every byte
// of a right-justified word.
//   char_i - 8-bit character to look for
//   word_i - 8*MAX_LEN-bit word, byte k holds character k (byte 0 = last char)
//   len_i  - number of valid characters
//   hit_o  - bit k set when byte k equals char_i and k < len_i
module letter_match
    import hangman_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic [7:0]           char_i,
    input  logic [8*MAX_LEN-1:0] word_i,
    input  logic [3:0]           len_i,
    output logic [MAX_LEN-1:0]   hit_o
);

    always_comb begin
        hit_o = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            hit_o[k] = (word_i[8*k +: 8] == char_i) && (k < int'(len_i));
        end
    end

endmodule

// File: rtl/guess_tracker.sv
// guess_tracker: hangman game state. Latches a word on new_game, then
// resolves one letter guess every two cycles, tracking the revealed mask,
// misses and used letters, and reports win/loss.
//   Clk, Reset           - clock, synchronous active-high reset
//   new_game, word, length - start a game with this word (length clamped)
//   guess_valid/guess_ready/guess_char - guess handshake
//   revealed, miss_count, used_letters - game progress
//   guess_done + guess_hit/guess_repeat/guess_bad - per-guess result pulse
//   game_won, game_lost  - end-of-game levels
//   dbg_state            - current FSM state, for observation
//
// Handshake: a guess transfers on a rising edge where guess_valid and
// guess_ready are both high and new_game is low. guess_ready is high only in
// PLAY; new_game in the same cycle discards the guess.
module guess_tracker
    import hangman_pkg::*;
#(
    parameter int MAX_LEN    = MAX_LEN_DEF,
    parameter int MAX_MISSES = MAX_MISSES_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 new_game,
    input  logic [8*MAX_LEN-1:0] word,
    input  logic [3:0]           length,
    input  logic                 guess_valid,
    input  logic [7:0]           guess_char,
    output logic                 guess_ready,
    output logic [MAX_LEN-1:0]   revealed,
    output logic [3:0]           miss_count,
    output logic [25:0]          used_letters,
    output logic                 guess_done,
    output logic                 guess_hit,
    output logic                 guess_repeat,
    output logic                 guess_bad,
    output logic                 game_won,
    output logic                 game_lost,
    output state_t               dbg_state
);

    state_t               state_q, state_d;
    logic [8*MAX_LEN-1:0] word_q, word_d;
    logic [3:0]           len_q, len_d;
    logic [MAX_LEN-1:0]   rev_q, rev_d;
    logic [3:0]           miss_q, miss_d;
    logic [25:0]          used_q, used_d;
    logic [7:0]           guess_q, guess_d;
    logic                 done_q, done_d;
    logic                 hit_q, hit_d;
    logic                 rep_q, rep_d;
    logic                 bad_q, bad_d;

    logic [7:0]         lc;
    logic               is_letter;
    logic [4:0]         idx;
    logic [MAX_LEN-1:0] match;
    logic [MAX_LEN-1:0] len_mask;

    assign lc        = to_lower(guess_q);
    assign is_letter = (lc >= CH_A_LOWER) && (lc <= CH_Z_LOWER);
    assign idx       = 5'(lc - CH_A_LOWER);

    letter_match #(.MAX_LEN(MAX_LEN)) u_match (
        .char_i (lc),
        .word_i (word_q),
        .len_i  (len_q),
        .hit_o  (match)
    );

    // Positions beyond the word count as revealed for the win test.
    always_comb begin
        len_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            len_mask[k] = (k < int'(len_q));
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        rev_d   = rev_q;
        miss_d  = miss_q;
        used_d  = used_q;
        guess_d = guess_q;
        done_d  = 1'b0;
        hit_d   = 1'b0;
        rep_d   = 1'b0;
        bad_d   = 1'b0;

        if (new_game) begin
            word_d  = word;
            len_d   = (length > 4'(MAX_LEN)) ? 4'(MAX_LEN) : length;
            rev_d   = '0;
            miss_d  = '0;
            used_d  = '0;
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: state_d = (len_q == 4'd0) ? ST_WON : ST_PLAY;
                ST_PLAY: begin
                    if (guess_valid) begin
                        guess_d = guess_char;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    done_d = 1'b1;
                    if (!is_letter) begin
                        bad_d = 1'b1;
                    end else if (used_q[idx]) begin
                        rep_d = 1'b1;
                    end else begin
                        used_d[idx] = 1'b1;
                        rev_d       = rev_q | match;
                        hit_d       = |match;
                        if (match == '0 && miss_q < 4'(MAX_MISSES)) begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                    if (&(rev_d | ~len_mask)) begin
                        state_d = ST_WON;
                    end else if (miss_d == 4'(MAX_MISSES)) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: ; // IDLE, WON, LOST hold until new_game
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            len_q   <= '0;
            rev_q   <= '0;
            miss_q  <= '0;
            used_q  <= '0;
            guess_q <= '0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            rep_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            rev_q   <= rev_d;
            miss_q  <= miss_d;
            used_q  <= used_d;
            guess_q <= guess_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            rep_q   <= rep_d;
            bad_q   <= bad_d;
        end
    end

    assign guess_ready  = (state_q == ST_PLAY);
    assign revealed     = rev_q;
    assign miss_count   = miss_q;
    assign used_letters = used_q;
    assign guess_done   = done_q;
    assign guess_hit    = hit_q;
    assign guess_repeat = rep_q;
    assign guess_bad    = bad_q;
    assign game_won     = (state_q == ST_WON);
    assign game_lost    = (state_q == ST_LOST);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_guess_tracker.sv
module tb_guess_tracker;
    import hangman_pkg::*;

    localparam int ML = 11;
    localparam int MM = 6;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          new_game = 1'b0;
    logic [8*ML-1:0] word = '0;
    logic [3:0]    length = '0;
    logic          guess_valid = 1'b0;
    logic [7:0]    guess_char = '0;
    logic          guess_ready;
    logic [ML-1:0] revealed;
    logic [3:0]    miss_count;
    logic [25:0]   used_letters;
    logic          guess_done, guess_hit, guess_repeat, guess_bad;
    logic          game_won, game_lost;
    state_t        dbg_state;

    int errors = 0;
    int checks = 0;

    // Reference model: the game as a set of guessed letters over a word.
    logic [7:0]  m_bytes[ML];
    int          m_len;
    logic [25:0] m_used;
    int          m_miss;

    guess_tracker dut (
        .Clk(Clk), .Reset(Reset), .new_game(new_game), .word(word),
        .length(length), .guess_valid(guess_valid), .guess_char(guess_char),
        .guess_ready(guess_ready), .revealed(revealed), .miss_count(miss_count),
        .used_letters(used_letters), .guess_done(guess_done), .guess_hit(guess_hit),
        .guess_repeat(guess_repeat), .guess_bad(guess_bad), .game_won(game_won),
        .game_lost(game_lost), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [8*ML-1:0] pack(input string s);
        logic [8*ML-1:0] w = '0;
        for (int i = 0; i < s.len(); i++) w[8*(s.len()-1-i) +: 8] = s[i];
        return w;
    endfunction

    // A position is uncovered once its lowercase letter has been guessed.
    function automatic logic [ML-1:0] m_revealed();
        logic [ML-1:0] r = '0;
        for (int k = 0; k < m_len; k++) begin
            if (m_bytes[k] >= 8'h61 && m_bytes[k] <= 8'h7A)
                r[k] = m_used[m_bytes[k] - 8'h61];
        end
        return r;
    endfunction

    function automatic logic m_won();
        logic [ML-1:0] r = m_revealed();
        for (int k = 0; k < m_len; k++) if (!r[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_lost();
        return !m_won() && (m_miss == MM);
    endfunction

    task automatic model_load(input logic [8*ML-1:0] w, input int len_in);
        m_len = (len_in > ML) ? ML : len_in;
        for (int k = 0; k < ML; k++) m_bytes[k] = w[8*k +: 8];
        m_used = '0;
        m_miss = 0;
    endtask

    task automatic check_progress(input string tag);
        chk({tag, "_rev"},  32'(revealed),     32'(m_revealed()));
        chk({tag, "_miss"}, 32'(miss_count),   32'(m_miss));
        chk({tag, "_used"}, 32'(used_letters), 32'(m_used));
        chk({tag, "_won"},  32'(game_won),     32'(m_won()));
        chk({tag, "_lost"}, 32'(game_lost),    32'(m_lost()));
    endtask

    task automatic start_game(input logic [8*ML-1:0] w, input int len_in, input string tag);
        word = w;
        length = 4'(len_in);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk({tag, "_load"}, 32'(dbg_state), 32'(ST_LOAD));
        chk({tag, "_load_done"}, 32'(guess_done), 32'd0);
        model_load(w, len_in);
        tick();
        chk({tag, "_start_state"}, 32'(dbg_state), (m_len == 0) ? 32'(ST_WON) : 32'(ST_PLAY));
        chk({tag, "_start_ready"}, 32'(guess_ready), (m_len == 0) ? 32'd0 : 32'd1);
        check_progress({tag, "_start"});
    endtask

    task automatic guess(input logic [7:0] g, input string tag);
        int n = 0;
        logic [7:0] lc;
        logic is_let, rep, hit;
        while (!guess_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(guess_ready), 32'd1);
        guess_valid = 1'b1;
        guess_char = g;
        tick();
        guess_valid = 1'b0;
        chk({tag, "_check_done"}, 32'(guess_done), 32'd0);
        chk({tag, "_check_ready"}, 32'(guess_ready), 32'd0);
        lc = (g >= 8'h41 && g <= 8'h5A) ? g + 8'd32 : g;
        is_let = (lc >= 8'h61 && lc <= 8'h7A);
        rep = is_let && m_used[lc - 8'h61];
        hit = 1'b0;
        if (is_let && !rep) begin
            for (int k = 0; k < m_len; k++) if (m_bytes[k] == lc) hit = 1'b1;
            m_used[lc - 8'h61] = 1'b1;
            if (!hit && m_miss < MM) m_miss++;
        end
        tick();
        chk({tag, "_done"}, 32'(guess_done), 32'd1);
        chk({tag, "_hit"},  32'(guess_hit),    32'(hit));
        chk({tag, "_rep"},  32'(guess_repeat), 32'(rep));
        chk({tag, "_bad"},  32'(guess_bad),    32'(!is_let));
        chk({tag, "_ready"}, 32'(guess_ready), 32'(!(m_won() || m_lost())));
        check_progress(tag);
    endtask

    initial begin
        logic [8*ML-1:0] w;
        int len, n;
        logic [7:0] c;

        // Reset state
        repeat (3) tick();
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_ready", 32'(guess_ready), 32'd0);
        chk("rst_rev", 32'(revealed), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_used", 32'(used_letters), 32'd0);
        chk("rst_flags", {26'd0, guess_done, guess_hit, guess_repeat, guess_bad, game_won, game_lost}, 32'd0);
        Reset = 1'b0;
        tick();
        chk("idle_hold", 32'(dbg_state), 32'(ST_IDLE));

        // "viler": one hit on byte 1
        start_game(pack("viler"), 5, "viler");
        guess("e", "viler_e");
        chk("viler_rev_const", 32'(revealed), 32'h002);
        chk("viler_used_e", 32'(used_letters[4]), 32'd1);

        // "needle": uppercase fold, then win
        start_game(pack("needle"), 6, "needle");
        guess("E", "needle_E");
        chk("needle_rev_const", 32'(revealed), 32'h019);
        guess("n", "needle_n");
        guess("d", "needle_d");
        guess("l", "needle_l");
        chk("needle_won_const", 32'(game_won), 32'd1);
        chk("needle_ready_const", 32'(guess_ready), 32'd0);

        // "dirks": six misses, then guesses are ignored
        start_game(pack("dirks"), 5, "dirks");
        guess("a", "dirks_a");
        guess("b", "dirks_b");
        guess("c", "dirks_c");
        guess("f", "dirks_f");
        guess("g", "dirks_g");
        guess("h", "dirks_h");
        chk("dirks_lost_const", 32'(game_lost), 32'd1);
        chk("dirks_miss_const", 32'(miss_count), 32'd6);
        guess_valid = 1'b1;
        guess_char = "i";
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dirks_after_done", 32'(guess_done), 32'd0);
            chk("dirks_after_state", 32'(dbg_state), 32'(ST_LOST));
        end
        guess_valid = 1'b0;
        check_progress("dirks_after");

        // "snowy": repeat and non-letter leave state untouched
        start_game(pack("snowy"), 5, "snowy");
        guess("s", "snowy_s1");
        guess("s", "snowy_s2");
        chk("snowy_rep_const", 32'(guess_repeat), 32'd1);
        chk("snowy_rev_const", 32'(revealed), 32'h010);
        guess("3", "snowy_3");
        chk("snowy_bad_const", 32'(guess_bad), 32'd1);
        chk("snowy_miss_const", 32'(miss_count), 32'd0);

        // new_game together with guess_valid
        start_game(pack("abc"), 3, "abc");
        guess("a", "abc_a");
        w = pack("xyz");
        word = w;
        length = 4'd3;
        new_game = 1'b1;
        guess_valid = 1'b1;
        guess_char = "b";
        tick();
        new_game = 1'b0;
        guess_valid = 1'b0;
        chk("ng_same_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("ng_same_done", 32'(guess_done), 32'd0);
        chk("ng_same_used", 32'(used_letters), 32'd0);
        chk("ng_same_rev", 32'(revealed), 32'd0);
        model_load(w, 3);
        tick();
        chk("ng_same_play", 32'(dbg_state), 32'(ST_PLAY));
        chk("ng_same_done2", 32'(guess_done), 32'd0);
        guess("z", "xyz_z");

        // new_game during CHECK aborts the guess
        guess_valid = 1'b1;
        guess_char = "x";
        tick();
        guess_valid = 1'b0;
        chk("ng_chk_state", 32'(dbg_state), 32'(ST_CHECK));
        w = pack("mop");
        word = w;
        length = 4'd3;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_chk_load", 32'(dbg_state), 32'(ST_LOAD));
        chk("ng_chk_done", 32'(guess_done), 32'd0);
        chk("ng_chk_miss", 32'(miss_count), 32'd0);
        chk("ng_chk_used", 32'(used_letters), 32'd0);
        chk("ng_chk_rev", 32'(revealed), 32'd0);
        model_load(w, 3);
        tick();
        chk("ng_chk_play", 32'(dbg_state), 32'(ST_PLAY));
        chk("ng_chk_done2", 32'(guess_done), 32'd0);
        guess("p", "mop_p");

        // Boundary lengths
        start_game(pack(""), 0, "len0");
        start_game(pack("abcdefghijk"), 13, "len13");
        guess("k", "len13_k");
        guess("a", "len13_a");
        chk("len13_rev_const", 32'(revealed), 32'h401);

        // Reset mid-game
        start_game(pack("hello"), 5, "hello");
        guess("l", "hello_l");
        Reset = 1'b1;
        tick();
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("midrst_outs", {3'd0, revealed, miss_count, guess_ready, guess_done, guess_hit,
            guess_repeat, guess_bad, game_won, game_lost}, 32'd0);
        chk("midrst_used", 32'(used_letters), 32'd0);
        Reset = 1'b0;
        tick();

        // Randomized games against the model
        for (int g = 0; g < 8; g++) begin
            len = $urandom_range(1, ML);
            w = '0;
            for (int k = 0; k < len; k++) w[8*k +: 8] = 8'h61 + 8'($urandom_range(0, 7));
            start_game(w, len, "rnd_start");
            n = 0;
            while (!(m_won() || m_lost()) && n < 60) begin
                case ($urandom_range(0, 9))
                    0: c = 8'h30 + 8'($urandom_range(0, 9));
                    1: c = 8'h41 + 8'($urandom_range(0, 11));
                    default: c = 8'h61 + 8'($urandom_range(0, 11));
                endcase
                guess(c, "rnd");
                n++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
